// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a host-side holding register.
// Serial_in is resynchronised, start bits are qualified at mid-bit,
// data is shifted in LSB first, and each good frame is loaded into
// RCV_datareg with read_not_ready_out set until the host acknowledges.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit
// between the data and stop bits and the sticky Error3 flag.
module uart_rx #(
  parameter int WORD_SIZE    = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 Serial_in,
  input  logic                 read_not_ready_in,
  output logic [WORD_SIZE-1:0] RCV_datareg,
  output logic                 read_not_ready_out,
  output logic                 Error1,
`ifdef UART_RX_PARITY_EN
  output logic                 Error3,
`endif
  output logic                 Error2
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(WORD_SIZE + 1);

  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] WORD_LAST = BW'(WORD_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // Line synchroniser
  logic sync1_q;
  logic rx_s_q;

  // Frame engine
  state_t                 state_q;
  logic [TW-1:0]          tmr_q;
  logic [BW-1:0]          bit_cnt_q;
  logic [WORD_SIZE-1:0]   shift_q;
  logic                   armed_q;
  logic                   load_pend_q;
  logic                   ferr_pend_q;
`ifdef UART_RX_PARITY_EN
  logic                   perr_pend_q;
  logic                   parity_err_q;
`endif

  // Host-visible registers
  logic [WORD_SIZE-1:0]   data_q;
  logic                   rdy_q;
  logic                   overrun_q;
  logic                   frame_err_q;

  // Mid-bit and full-bit timing strobes
  logic half_tick;
  logic bit_tick;

  assign half_tick = (tmr_q == HALF_LAST);
  assign bit_tick  = (tmr_q == BIT_LAST);

  // Two-flop synchroniser, preset high so an idle line is never mistaken for a start bit
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge values of the others.
    if (reset) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= Serial_in;
      rx_s_q  <= sync1_q;
    end
  end

  // Receive FSM: start qualification, bit timing, shifting and frame verdicts
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      armed_q     <= 1'b0;
      load_pend_q <= 1'b0;
      ferr_pend_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_pend_q <= 1'b0;
`endif
    end else begin
      // Verdict strobes are single-cycle pulses
      load_pend_q <= 1'b0;
      ferr_pend_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_pend_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          tmr_q <= '0;
          // A line held low (break) must go high before another frame can start
          if (rx_s_q) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            armed_q <= 1'b0;
            state_q <= S_START;
          end
        end

        S_START: begin
          if (half_tick) begin
            tmr_q     <= '0;
            bit_cnt_q <= '0;
            // Still low at mid-bit: a real start bit; otherwise a glitch
            state_q   <= rx_s_q ? S_IDLE : S_DATA;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end

        S_DATA: begin
          if (bit_tick) begin
            tmr_q     <= '0;
            shift_q   <= {rx_s_q, shift_q[WORD_SIZE-1:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == WORD_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (bit_tick) begin
            tmr_q       <= '0;
            // Even parity: data bits plus parity bit must hold an even count of ones
            perr_pend_q <= (^shift_q) ^ rx_s_q;
            state_q     <= S_STOP;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (bit_tick) begin
            tmr_q   <= '0;
            state_q <= S_IDLE;
            if (rx_s_q) load_pend_q <= 1'b1;
            else        ferr_pend_q <= 1'b1;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Holding register and sticky flags; a frame event in the ack cycle takes priority
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q       <= '0;
      rdy_q        <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      if (load_pend_q) begin
        data_q <= shift_q;
        rdy_q  <= 1'b1;
      end else if (read_not_ready_in) begin
        rdy_q <= 1'b0;
      end

      // Overrun only when an unread word is overwritten without an ack
      if (load_pend_q && rdy_q && !read_not_ready_in) overrun_q <= 1'b1;
      else if (read_not_ready_in)                     overrun_q <= 1'b0;

      if (ferr_pend_q)            frame_err_q <= 1'b1;
      else if (read_not_ready_in) frame_err_q <= 1'b0;

`ifdef UART_RX_PARITY_EN
      if (perr_pend_q)            parity_err_q <= 1'b1;
      else if (read_not_ready_in) parity_err_q <= 1'b0;
`endif
    end
  end

  assign RCV_datareg        = data_q;
  assign read_not_ready_out = rdy_q;
  assign Error1             = overrun_q;
  assign Error2             = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign Error3             = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed testbench for uart_rx (WORD_SIZE=8, CLKS_PER_BIT=16).
// Frames are driven bit by bit on the falling clock edge; outputs are
// sampled on the falling edge, well away from the active rising edge.
// Build with UART_RX_PARITY_EN defined to include the parity checks.
module tb_uart_rx;

  localparam int BIT = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       Serial_in;
  logic       read_not_ready_in;
  logic [7:0] RCV_datareg;
  logic       read_not_ready_out;
  logic       Error1;
  logic       Error2;
`ifdef UART_RX_PARITY_EN
  logic       Error3;
`endif

  int n_checks = 0;
  int n_errors = 0;

  uart_rx #(
    .WORD_SIZE   (8),
    .CLKS_PER_BIT(BIT)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .Serial_in         (Serial_in),
    .read_not_ready_in (read_not_ready_in),
    .RCV_datareg       (RCV_datareg),
    .read_not_ready_out(read_not_ready_out),
    .Error1            (Error1),
`ifdef UART_RX_PARITY_EN
    .Error3            (Error3),
`endif
    .Error2            (Error2)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_ack();
    read_not_ready_in = 1'b1;
    @(negedge clock);
    read_not_ready_in = 1'b0;
    @(negedge clock);
  endtask

  // One full frame, LSB first. stop_bit=0 forces a framing error,
  // par_flip inverts the parity bit, ack_at_load pulses the ack so it
  // lands on the cycle the word is loaded (11 cycles into the stop bit).
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input logic par_flip, input bit ack_at_load);
    logic [7:0] d;
    d = data;
    Serial_in = 1'b0;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      Serial_in = d[i];
      idle(BIT);
    end
`ifdef UART_RX_PARITY_EN
    Serial_in = (^d) ^ par_flip;
    idle(BIT);
`else
    if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
    Serial_in = stop_bit;
    if (ack_at_load) begin
      idle(11);
      read_not_ready_in = 1'b1;
      @(negedge clock);
      read_not_ready_in = 1'b0;
      idle(4);
    end else begin
      idle(BIT);
    end
    Serial_in = 1'b1;
  endtask

  initial begin
    reset             = 1'b1;
    Serial_in         = 1'b1;
    read_not_ready_in = 1'b0;
    idle(3);

    // Reset state
    check("rst_data", RCV_datareg, 8'h00);
    check("rst_rdy",  read_not_ready_out, 1'b0);
    check("rst_e1",   Error1, 1'b0);
    check("rst_e2",   Error2, 1'b0);
    reset = 1'b0;
    idle(5);

    // 1: single word 0x41, then ack
    send_frame(8'h41, 1'b1, 1'b0, 1'b0);
    check("t1_data", RCV_datareg, 8'h41);
    check("t1_rdy",  read_not_ready_out, 1'b1);
    check("t1_e1",   Error1, 1'b0);
    check("t1_e2",   Error2, 1'b0);
    pulse_ack();
    check("t1_ack_rdy", read_not_ready_out, 1'b0);
    idle(8);

    // 2: 4-cycle low glitch is rejected at mid start bit
    Serial_in = 1'b0;
    idle(4);
    Serial_in = 1'b1;
    idle(40);
    check("t2_rdy",  read_not_ready_out, 1'b0);
    check("t2_data", RCV_datareg, 8'h41);
    check("t2_e2",   Error2, 1'b0);

    // 3: framing error on 0x55, then a good 0x3C
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    check("t3_e2",   Error2, 1'b1);
    check("t3_rdy",  read_not_ready_out, 1'b0);
    check("t3_data", RCV_datareg, 8'h41);
    idle(32);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    check("t3_data2", RCV_datareg, 8'h3C);
    check("t3_rdy2",  read_not_ready_out, 1'b1);
    check("t3_e2_sticky", Error2, 1'b1);
    pulse_ack();
    check("t3_ack_e2",  Error2, 1'b0);
    check("t3_ack_rdy", read_not_ready_out, 1'b0);
    idle(8);

    // 4: back-to-back 0x41, 0x42 without ack -> overrun
    send_frame(8'h41, 1'b1, 1'b0, 1'b0);
    check("t4_e1_first", Error1, 1'b0);
    send_frame(8'h42, 1'b1, 1'b0, 1'b0);
    check("t4_data", RCV_datareg, 8'h42);
    check("t4_rdy",  read_not_ready_out, 1'b1);
    check("t4_e1",   Error1, 1'b1);
    pulse_ack();
    check("t4_ack_rdy", read_not_ready_out, 1'b0);
    check("t4_ack_e1",  Error1, 1'b0);
    check("t4_ack_e2",  Error2, 1'b0);
    idle(8);

    // 5: reset in the middle of 0xA5 data bits, then 0x5A
    Serial_in = 1'b0;
    idle(BIT);
    Serial_in = 1'b1; idle(BIT);
    Serial_in = 1'b0; idle(BIT);
    Serial_in = 1'b1; idle(BIT);
    reset     = 1'b1;
    Serial_in = 1'b1;
    idle(3);
    check("t5_rst_data", RCV_datareg, 8'h00);
    check("t5_rst_rdy",  read_not_ready_out, 1'b0);
    reset = 1'b0;
    idle(20);
    check("t5_no_partial", read_not_ready_out, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    check("t5_data", RCV_datareg, 8'h5A);
    check("t5_rdy",  read_not_ready_out, 1'b1);
    check("t5_e1",   Error1, 1'b0);
    check("t5_e2",   Error2, 1'b0);
    idle(8);

    // Ack landing on the load cycle: new word wins, no overrun
    send_frame(8'hC3, 1'b1, 1'b0, 1'b1);
    check("tk_data", RCV_datareg, 8'hC3);
    check("tk_rdy",  read_not_ready_out, 1'b1);
    check("tk_e1",   Error1, 1'b0);
    pulse_ack();
    check("tk_ack_rdy", read_not_ready_out, 1'b0);
    idle(8);

`ifdef UART_RX_PARITY_EN
    // 6: 0x07 with correct even parity (1), then with parity 0
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    check("t6_e3_ok", Error3, 1'b0);
    check("t6_data",  RCV_datareg, 8'h07);
    pulse_ack();
    idle(8);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    check("t6_e3_bad", Error3, 1'b1);
    check("t6_data2",  RCV_datareg, 8'h07);
    check("t6_rdy2",   read_not_ready_out, 1'b1);
    pulse_ack();
    check("t6_ack_e3", Error3, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
